// File: rtl/forwarding_hazard_unit.sv
// ----------------------------------------------------------------------------
// forwarding_hazard_unit
// Control side of the EX-stage operand forwarding muxes in a 5-stage MIPS
// pipeline. Tracks the destination of the instructions in EX, MEM and WB,
// selects the forwarding source for ALU-A / ALU-B, and detects load-use
// hazards.
//
// Ports:
//   Clk, Reset         pipeline clock (rising edge), synchronous active-high reset
//   id_valid           ID stage holds a real instruction
//   id_rs / id_rt      ID source registers, qualified by id_rs_used / id_rt_used
//   id_dest            ID destination register (after RegDst selection)
//   id_reg_write       ID instruction writes the register file
//   id_mem_read        ID instruction is a load
//   flush              squash the instruction entering EX
//   stall              hold PC and IF/ID, bubble into EX (combinational)
//   fwd_a_sel/b_sel    00 regfile, 01 EX/MEM result, 10 MEM/WB result
//   stall_count        (STALL_COUNT_EN only) number of stall cycles, wraps
//
// Build option: define STALL_COUNT_EN to add the stall_count output.
// ----------------------------------------------------------------------------
module forwarding_hazard_unit #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic                  stall,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel
`ifdef STALL_COUNT_EN
   ,
   output logic [31:0]           stall_count
`endif
);

   localparam int unsigned CNT_W = 32;

   // Per-stage tracking entry
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dest;
      logic                  reg_write;
      logic                  mem_read;
   } stage_t;

   // EX additionally remembers which sources its instruction reads
   typedef struct packed {
      stage_t                st;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic                  rs_used;
      logic                  rt_used;
   } ex_t;

   ex_t    ex_q,  ex_d;
   stage_t mem_q, mem_d;
   stage_t wb_q,  wb_d;

   // Register 0 is hard-wired, so it never counts as a produced value
   function automatic logic is_writer(input stage_t s);
      return s.valid & s.reg_write & (s.dest != '0);
   endfunction

   // MEM holds the youngest result, so it wins over WB. The WB leg is not
   // qualified by the used flag: an unused operand ignores the mux anyway.
   function automatic logic [1:0] sel_for(input logic                  used,
                                          input logic [REG_ADDR_W-1:0] src,
                                          input stage_t                mem,
                                          input stage_t                wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && is_writer(mem) && (mem.dest == src)) begin
         sel = 2'b01;
      end else if (is_writer(wb) && (wb.dest == src)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   // Load-use detection and forwarding selects
   always_comb begin
      stall     = id_valid & ex_q.st.valid & ex_q.st.mem_read &
                  (ex_q.st.dest != '0) &
                  ((id_rs_used & (id_rs == ex_q.st.dest)) |
                   (id_rt_used & (id_rt == ex_q.st.dest)));
      fwd_a_sel = sel_for(ex_q.rs_used, ex_q.rs, mem_q, wb_q);
      fwd_b_sel = sel_for(ex_q.rt_used, ex_q.rt, mem_q, wb_q);
   end

   // Next-state: MEM/WB always advance; EX takes ID or a bubble
   always_comb begin
      ex_d  = '0;
      mem_d = ex_q.st;
      wb_d  = mem_q;
      if (id_valid && !stall && !flush) begin
         ex_d.st.valid     = 1'b1;
         ex_d.st.dest      = id_dest;
         ex_d.st.reg_write = id_reg_write;
         ex_d.st.mem_read  = id_mem_read;
         ex_d.rs           = id_rs;
         ex_d.rt           = id_rt;
         ex_d.rs_used      = id_rs_used;
         ex_d.rt_used      = id_rt_used;
      end
   end

   // Stage tracking registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef STALL_COUNT_EN
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   // Free-running stall-cycle counter, wraps naturally
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_forwarding_hazard_unit
// Scenario tasks drive instruction streams into the ID-side ports; the
// expected {stall, fwd_a_sel, fwd_b_sel} for each cycle is queued when the
// cycle is driven and popped when the outputs are sampled mid-cycle.
// ----------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_rs_used, id_rt_used, id_reg_write, id_mem_read, flush;
   logic       stall;
   logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rsu;
      logic       rtu;
      logic [4:0] dest;
      logic       rw;
      logic       mr;
      logic       fl;
   } stim_t;

   logic [4:0] exp_q[$];

   always #5 Clk = ~Clk;

   forwarding_hazard_unit #(.REG_ADDR_W(5)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .id_dest      (id_dest),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .stall        (stall),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel)
`ifdef STALL_COUNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   function automatic stim_t ins(input int rs, input int rt, input logic rsu,
                                 input logic rtu, input int dest,
                                 input logic rw, input logic mr);
      stim_t s;
      s      = '0;
      s.v    = 1'b1;
      s.rs   = 5'(rs);
      s.rt   = 5'(rt);
      s.rsu  = rsu;
      s.rtu  = rtu;
      s.dest = 5'(dest);
      s.rw   = rw;
      s.mr   = mr;
      return s;
   endfunction

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      @(negedge Clk);
      Reset        = s.rst;
      id_valid     = s.v;
      id_rs        = s.rs;
      id_rt        = s.rt;
      id_rs_used   = s.rsu;
      id_rt_used   = s.rtu;
      id_dest      = s.dest;
      id_reg_write = s.rw;
      id_mem_read  = s.mr;
      flush        = s.fl;
   endtask

   // Drive one cycle, record its expectation, settle before sampling
   task automatic apply(input stim_t s, input logic [4:0] e);
      drive(s);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic drain();
      repeat (3) drive(nop());
   endtask

   task automatic test_reset();
      stim_t s;
      logic [4:0] got, e;
      repeat (2) begin
         s     = stim_t'({$urandom, $urandom});
         s.rst = 1'b1;
         drive(s);
      end
      s     = stim_t'({$urandom, $urandom});
      s.rst = 1'b0;
      apply(s, 5'b0_00_00);
      got = {stall, fwd_a_sel, fwd_b_sel};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", got, e);
      end
`ifdef STALL_COUNT_EN
      checks++;
      if (stall_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", stall_count);
      end
`endif
   endtask

   task automatic test_fwd_exmem();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      drain();
      st.push_back(ins(1, 2, 1, 1, 3, 1, 0)); ex.push_back(5'b0_00_00); // add $3,$1,$2
      st.push_back(ins(3, 4, 1, 1, 5, 1, 0)); ex.push_back(5'b0_00_00); // sub $5,$3,$4
      st.push_back(nop());                    ex.push_back(5'b0_01_00); // sub in EX
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL fwd_exmem row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_fwd_memwb();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      drain();
      st.push_back(ins(1, 2, 1, 1, 3, 1, 0)); ex.push_back(5'b0_00_00); // add $3
      st.push_back(ins(1, 2, 1, 1, 6, 1, 0)); ex.push_back(5'b0_00_00); // or $6
      st.push_back(ins(8, 3, 1, 1, 7, 1, 0)); ex.push_back(5'b0_00_00); // and $7,$8,$3
      st.push_back(nop());                    ex.push_back(5'b0_00_10); // and in EX
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL fwd_memwb row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_mem_priority();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      drain();
      st.push_back(ins(1, 2, 1, 1, 3, 1, 0)); ex.push_back(5'b0_00_00);
      st.push_back(ins(1, 2, 1, 1, 3, 1, 0)); ex.push_back(5'b0_00_00);
      st.push_back(ins(3, 3, 1, 1, 9, 1, 0)); ex.push_back(5'b0_00_00);
      st.push_back(nop());                    ex.push_back(5'b0_01_01); // both match, MEM wins
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mem_priority row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      drain();
      st.push_back(ins(1, 2, 1, 1, 3, 1, 0)); ex.push_back(5'b0_00_00); // $3
      st.push_back(ins(3, 3, 1, 1, 4, 1, 0)); ex.push_back(5'b0_00_00); // $4 <- $3,$3
      st.push_back(ins(4, 3, 1, 1, 5, 1, 0)); ex.push_back(5'b0_01_01); // $5 <- $4,$3
      st.push_back(ins(5, 4, 0, 1, 6, 1, 0)); ex.push_back(5'b0_01_10); // rs unused
      st.push_back(nop());                    ex.push_back(5'b0_00_10);
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL back_to_back row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_reg_zero();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      drain();
      st.push_back(ins(1, 2, 1, 1, 0, 1, 0)); ex.push_back(5'b0_00_00); // writes $0
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      st.push_back(ins(0, 0, 1, 1, 6, 1, 0)); ex.push_back(5'b0_00_00); // reads $0
      st.push_back(ins(1, 0, 1, 0, 0, 1, 1)); ex.push_back(5'b0_00_00); // lw $0; WB holds $0 writer
      st.push_back(ins(0, 0, 1, 1, 7, 1, 0)); ex.push_back(5'b0_00_00); // no stall on $0
      st.push_back(nop());                    ex.push_back(5'b0_00_00); // MEM holds $0 load
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reg_zero row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
`ifdef STALL_COUNT_EN
      logic [31:0] base;
`endif
      drain();
`ifdef STALL_COUNT_EN
      base = stall_count;
`endif
      st.push_back(ins(1, 0, 1, 0, 2, 1, 1)); ex.push_back(5'b0_00_00); // lw $2
      st.push_back(ins(2, 2, 1, 1, 4, 1, 0)); ex.push_back(5'b1_00_00); // add $4,$2,$2
      st.push_back(ins(2, 2, 1, 1, 4, 1, 0)); ex.push_back(5'b0_00_00); // held add
      st.push_back(nop());                    ex.push_back(5'b0_10_10);
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL load_use row %0d: got %b expected %b", i, got, e);
         end
      end
`ifdef STALL_COUNT_EN
      checks++;
      if (stall_count - base !== 32'd1) begin
         errors++;
         $display("FAIL load_use_count: got %0d expected 1", stall_count - base);
      end
`endif
   endtask

   task automatic test_flush();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      stim_t s;
      drain();
      st.push_back(ins(1, 0, 1, 0, 2, 1, 1)); ex.push_back(5'b0_00_00); // lw $2
      s = ins(2, 0, 1, 0, 8, 1, 0); s.fl = 1'b1;
      st.push_back(s);                        ex.push_back(5'b1_00_00); // flush + stall
      st.push_back(ins(9, 10, 1, 1, 11, 1, 0)); ex.push_back(5'b0_00_00);
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      s = ins(1, 2, 1, 1, 3, 1, 0); s.fl = 1'b1;
      st.push_back(s);                        ex.push_back(5'b0_00_00); // squashed $3 writer
      st.push_back(ins(3, 3, 1, 1, 12, 1, 0)); ex.push_back(5'b0_00_00);
      st.push_back(nop());                    ex.push_back(5'b0_00_00); // no MEM forward
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL flush row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_invalid();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      stim_t s;
      drain();
      s = ins(0, 0, 0, 0, 3, 1, 1); s.v = 1'b0;
      st.push_back(s);                        ex.push_back(5'b0_00_00); // invalid load $3
      st.push_back(ins(3, 3, 1, 1, 9, 1, 0)); ex.push_back(5'b0_00_00);
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      st.push_back(ins(1, 0, 1, 0, 2, 1, 1)); ex.push_back(5'b0_00_00); // lw $2
      s = ins(2, 2, 1, 1, 4, 1, 0); s.v = 1'b0;
      st.push_back(s);                        ex.push_back(5'b0_00_00); // invalid reader
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL invalid row %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t st[$];
      logic [4:0] ex[$];
      logic [4:0] got, e;
      stim_t s;
      drain();
      st.push_back(ins(1, 0, 1, 0, 2, 1, 1)); ex.push_back(5'b0_00_00); // lw $2
      s = ins(2, 0, 1, 0, 4, 1, 0); s.rst = 1'b1;
      st.push_back(s);                        ex.push_back(5'b1_00_00); // reset, lw in EX
      st.push_back(ins(2, 0, 1, 0, 4, 1, 0)); ex.push_back(5'b0_00_00); // lw discarded
      st.push_back(nop());                    ex.push_back(5'b0_00_00); // no residual forward
      st.push_back(nop());                    ex.push_back(5'b0_00_00);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         got = {stall, fwd_a_sel, fwd_b_sel};
         e   = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_mid row %0d: got %b expected %b", i, got, e);
         end
      end
`ifdef STALL_COUNT_EN
      checks++;
      if (stall_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_count: got %0d expected 0", stall_count);
      end
`endif
   endtask

   initial begin
      Reset        = 1'b1;
      id_valid     = 1'b0;
      id_rs        = '0;
      id_rt        = '0;
      id_rs_used   = 1'b0;
      id_rt_used   = 1'b0;
      id_dest      = '0;
      id_reg_write = 1'b0;
      id_mem_read  = 1'b0;
      flush        = 1'b0;
      test_reset();
      test_fwd_exmem();
      test_fwd_memwb();
      test_mem_priority();
      test_back_to_back();
      test_reg_zero();
      test_load_use();
      test_flush();
      test_invalid();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
